// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: owns the PC, one outstanding fetch, registered IF/ID buffer
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;
  logic        fault_q, fault_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    fault_d = fault_q;

    case (state_q)
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
        // The pending request keeps its old address; only the PC moves.
        if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d  = mem_rsp_data;
            fault_d = mem_rsp_err;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Request address is captured on entry to REQ and held until accepted.
    if (state_d == ST_REQ && state_q != ST_REQ) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= 32'h0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = addr_q;
  assign out_valid     = (state_q == ST_HOLD);
  assign out_pc        = pc_q;
  assign out_inst      = inst_q;
  assign out_fault     = fault_q;
  assign busy          = (state_q != ST_HOLD);

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with a one-outstanding memory model
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  out_t        exp_out_q[$];
  logic [31:0] exp_addr_q[$];
  int          fire_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_acc = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          rsp_delay = 1;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] ovr_addr = 32'hFFFF_FFFF;
  logic [31:0] ovr_data = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_fault(out_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ovr_addr) return ovr_data;
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic out_t mk_out(input logic [31:0] pc, input logic fault);
    out_t o;
    o.pc = pc;
    o.inst = mem_word(pc);
    o.fault = fault;
    return o;
  endfunction

  // One clock: sample handshakes before the edge, score them, then update the memory model.
  task automatic tick();
    logic        acc, rspf, ofire;
    logic [31:0] aaddr, ea;
    out_t        obs, eo;
    @(negedge clk);
    acc   = mem_req_valid && mem_req_ready && !rst;
    aaddr = mem_req_addr;
    rspf  = mem_rsp_valid;
    ofire = out_valid && out_ready && !rst;
    obs.pc = out_pc;
    obs.inst = out_inst;
    obs.fault = out_fault;
    if (acc) begin
      n_checks++;
      n_acc++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_addr: unexpected request at %h, none expected", aaddr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (aaddr !== ea) begin
          n_fail++;
          $display("FAIL req_addr: got %h expected %h", aaddr, ea);
        end
      end
    end
    if (ofire) begin
      n_checks++;
      n_out++;
      fire_cyc.push_back(cyc);
      if (exp_out_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_xfer: unexpected pc=%h inst=%h fault=%b", obs.pc, obs.inst, obs.fault);
      end else begin
        eo = exp_out_q.pop_front();
        if (obs !== eo) begin
          n_fail++;
          $display("FAIL out_xfer: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=%b",
                   obs.pc, obs.inst, obs.fault, eo.pc, eo.inst, eo.fault);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
    end else begin
      if (rspf) begin
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
      end
      if (acc) begin
        pend = 1'b1;
        cnt = rsp_delay;
        pend_addr = aaddr;
      end
      if (pend) begin
        if (cnt <= 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data = mem_word(pend_addr);
          mem_rsp_err = (pend_addr == err_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic run_outs(input int target, input int budget, input string name);
    int k = 0;
    while (n_out < target && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (n_out < target) begin
      n_fail++;
      $display("FAIL %s: timeout, transfers %0d expected %0d", name, n_out, target);
    end
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int k = 0;
    while (n_acc < target && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (n_acc < target) begin
      n_fail++;
      $display("FAIL %s: timeout, accepts %0d expected %0d", name, n_acc, target);
    end
  endtask

  task automatic wait_out_valid(input int budget, input string name);
    int k = 0;
    while (out_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: timeout waiting out_valid, got %b expected 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks += 6;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 1", mem_req_valid); end
    if (mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_req_addr: got %h expected %h", mem_req_addr, RESET_PC); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst: got %h expected 0", out_inst); end
    if (out_fault !== 1'b0) begin n_fail++; $display("FAIL rst_out_fault: got %b expected 0", out_fault); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", busy); end
  endtask

  task automatic test_sequential();
    int n0 = n_out;
    fire_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(RESET_PC + 32'(4 * i));
      exp_out_q.push_back(mk_out(RESET_PC + 32'(4 * i), 1'b0));
    end
    rsp_delay = 1;
    out_ready = 1'b1;
    mem_req_ready = 1'b1;
    run_outs(n0 + 3, 30, "seq_outs");
    mem_req_ready = 1'b0;
    n_checks += 2;
    if (fire_cyc.size() < 3) begin
      n_fail += 2;
      $display("FAIL seq_rate: got %0d transfers expected 3", fire_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        if (fire_cyc[i] - fire_cyc[i-1] != 3) begin
          n_fail++;
          $display("FAIL seq_rate: gap %0d expected 3", fire_cyc[i] - fire_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_hold_stall();
    int n0 = n_out;
    ovr_addr = 32'h3000_000C;
    ovr_data = 32'h0010_0093;
    exp_addr_q.push_back(32'h3000_000C);
    exp_out_q.push_back(mk_out(32'h3000_000C, 1'b0));
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    wait_out_valid(10, "hold_enter");
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks += 4;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
      if (out_pc !== 32'h3000_000C) begin n_fail++; $display("FAIL hold_pc: got %h expected 3000000c", out_pc); end
      if (out_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL hold_inst: got %h expected 00100093", out_inst); end
      if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_noreq: got %b expected 0", mem_req_valid); end
    end
    out_ready = 1'b1;
    run_outs(n0 + 1, 3, "hold_release");
    mem_req_ready = 1'b0;
    n_checks += 2;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_next_req: got %b expected 1", mem_req_valid); end
    if (mem_req_addr !== 32'h3000_0010) begin n_fail++; $display("FAIL hold_next_addr: got %h expected 30000010", mem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    int n0 = n_out;
    ovr_addr = 32'h3000_0010;
    ovr_data = 32'hDEAD_BEEF;
    rsp_delay = 4;
    exp_addr_q.push_back(32'h3000_0010);
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 1, 5, "rw_accept");
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy: got %b expected 1", busy); end
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_noreq: got %b expected 0", mem_req_valid); end
    exp_addr_q.push_back(32'h8000_0010);
    exp_out_q.push_back(mk_out(32'h8000_0010, 1'b0));
    mem_req_ready = 1'b1;
    run_outs(n0 + 1, 30, "rw_refetch");
    mem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    int n0 = n_out;
    rsp_delay = 2;
    exp_addr_q.push_back(32'h8000_0014);
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 1, 5, "sc_accept");
    mem_req_ready = 1'b0;
    tick();
    n_checks++;
    if (mem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sc_rsp_present: got %b expected 1", mem_rsp_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0203;
    tick();
    redirect_valid = 1'b0;
    n_checks += 2;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL sc_req_valid: got %b expected 1", mem_req_valid); end
    if (mem_req_addr !== 32'h4000_0200) begin n_fail++; $display("FAIL sc_req_addr: got %h expected 40000200", mem_req_addr); end
    rsp_delay = 1;
    exp_addr_q.push_back(32'h4000_0200);
    exp_out_q.push_back(mk_out(32'h4000_0200, 1'b0));
    mem_req_ready = 1'b1;
    run_outs(n0 + 1, 20, "sc_refetch");
    mem_req_ready = 1'b0;
  endtask

  task automatic test_req_stall_redirect();
    int n0 = n_out;
    exp_addr_q.push_back(32'h4000_0204);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i == 1);
      redirect_pc = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4000_0204) begin
        n_fail++;
        $display("FAIL stall_addr: got valid=%b addr=%h expected valid=1 addr=40000204", mem_req_valid, mem_req_addr);
      end
    end
    exp_addr_q.push_back(32'h0000_0100);
    exp_out_q.push_back(mk_out(32'h0000_0100, 1'b0));
    mem_req_ready = 1'b1;
    run_outs(n0 + 1, 20, "stall_refetch");
    mem_req_ready = 1'b0;
  endtask

  task automatic test_fault();
    int n0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n0 = n_out;
    ovr_addr = 32'hFFFF_FFFF;
    err_addr = 32'h3000_0004;
    exp_addr_q.push_back(32'h3000_0000);
    exp_addr_q.push_back(32'h3000_0004);
    exp_out_q.push_back(mk_out(32'h3000_0000, 1'b0));
    exp_out_q.push_back(mk_out(32'h3000_0004, 1'b1));
    out_ready = 1'b1;
    mem_req_ready = 1'b1;
    run_outs(n0 + 2, 20, "fault_outs");
    mem_req_ready = 1'b0;
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_in_hold();
    exp_addr_q.push_back(32'h3000_0008);
    exp_out_q.push_back(mk_out(32'h3000_0008, 1'b0));
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    wait_out_valid(10, "rh_enter");
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_out_q.delete();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rh_out_valid: got %b expected 0", out_valid); end
    if (mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rh_req_addr: got %h expected %h", mem_req_addr, RESET_PC); end
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rh_req_valid: got %b expected 1", mem_req_valid); end
    if (out_inst !== 32'h0 || out_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rh_out_clear: got inst=%h fault=%b expected 0/0", out_inst, out_fault);
    end
  endtask

  task automatic test_wrap();
    int n0 = n_out;
    exp_addr_q.push_back(RESET_PC);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_out_q.push_back(mk_out(32'hFFFF_FFFC, 1'b0));
    exp_out_q.push_back(mk_out(32'h0000_0000, 1'b0));
    mem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    run_outs(n0 + 2, 30, "wrap_outs");
    mem_req_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    mem_rsp_err = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_req_stall_redirect();
    test_fault();
    test_reset_in_hold();
    test_wrap();
    repeat (3) tick();
    n_checks += 2;
    if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL leftover_addr: got %0d pending expected 0", exp_addr_q.size()); end
    if (exp_out_q.size() != 0) begin n_fail++; $display("FAIL leftover_out: got %0d pending expected 0", exp_out_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
